// File: rtl/prog_loader.sv
// Streams instruction words into the instruction RAM and then releases the processor to run from PC 0.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to treat the last beat as a sum-of-words checksum.
module prog_loader #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [DATA_W-1:0] wdata,
  output logic              working,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERROR} loaderState_t;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  loaderState_t state;
  logic         accept;
  logic         csumBeat;
  logic         csumOk;

  assign accept = s_valid && s_ready;

  function automatic logic [ADDR_W:0] satInc(input logic [ADDR_W:0] c);
    return (c == COUNT_MAX) ? c : c + (ADDR_W+1)'(1);
  endfunction

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  assign csumBeat = s_last;
  assign csumOk   = (s_data == csum);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if ((state == IDLE || state == ERROR) && start) begin
      csum <= '0;
    end else if (state == LOAD && !halt && accept && !s_last) begin
      csum <= csum + s_data;
    end
  end
`else
  assign csumBeat = 1'b0;
  assign csumOk   = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      addr    <= '0;
      wr      <= 1'b0;
      wdata   <= '0;
      working <= 1'b0;
      count   <= '0;
      err     <= '0;
    end else begin
      wr <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          working <= 1'b0;
          if (start) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            count   <= '0;
            err     <= '0;
          end
        end
        LOAD: begin
          // halt outranks any beat presented in the same cycle, including the last one
          if (halt) begin
            state   <= IDLE;
            s_ready <= 1'b0;
          end else if (accept) begin
            if (csumBeat) begin
              s_ready <= 1'b0;
              if (csumOk) begin
                state <= FLUSH;
              end else begin
                err[1] <= 1'b1;
                state  <= ERROR;
              end
            end else begin
              addr  <= BASE + count[ADDR_W-1:0];
              wdata <= s_data;
              wr    <= 1'b1;
              count <= satInc(count);
              if (s_last) begin
                state   <= FLUSH;
                s_ready <= 1'b0;
              end else if (count == LAST_SLOT) begin
                err[0]  <= 1'b1;
                state   <= ERROR;
                s_ready <= 1'b0;
              end
            end
          end
        end
        FLUSH: begin
          addr  <= BASE;
          state <= RUN;
        end
        RUN: begin
          addr <= BASE;
          if (halt) begin
            state   <= IDLE;
            working <= 1'b0;
          end else begin
            working <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
